// File: rtl/uart_tx_sequencer_if.sv
// TX FIFO read-side bundle between the tx_queue FIFO and the frame sequencer.
//   fifo_empty : FIFO empty flag (driven by the FIFO)
//   fifo_dout  : FIFO head word, valid combinationally while !fifo_empty (driven by the FIFO)
//   fifo_re    : one-cycle pop strobe, FIFO advances on that clock edge (driven by the sequencer)
// master = sequencer side, slave = FIFO side.
interface uart_tx_sequencer_if #(
  parameter int CHAR_WIDTH = 8
);
  logic                  fifo_empty;
  logic [CHAR_WIDTH-1:0] fifo_dout;
  logic                  fifo_re;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_re
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_re
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer. Pops bytes from the TX FIFO and serialises them on tx:
// start bit, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits, one bit period
// each (bit period = spacing of bit_tick pulses). Frame configuration is snapshotted at pop
// time; back-to-back frames start directly from the closing stop tick.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   bit_tick          : one-cycle pulse per bit period
//   enable            : allow new frames to start (current frame always completes)
//   data_bits_count   : data bits = value + 5
//   parity_type       : 00 none, 01 odd, 10 even, 11 none
//   double_stop_bits  : 1 = two stop bits
//   fifo              : TX FIFO read interface (master side)
//   tx                : registered serial line, idle high
//   busy              : high whenever the sequencer is not idle
//   tx_done           : one-cycle pulse when the last frame ends with the FIFO empty
module uart_tx_sequencer #(
  parameter int CHAR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bit_tick,
  input  logic                      enable,
  input  logic [1:0]                data_bits_count,
  input  logic [1:0]                parity_type,
  input  logic                      double_stop_bits,
  uart_tx_sequencer_if.master       fifo,
  output logic                      tx,
  output logic                      busy,
  output logic                      tx_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] STOP1  = 3'd5;
  localparam logic [2:0] STOP2  = 3'd6;

  logic [2:0]            state;
  logic [CHAR_WIDTH-1:0] shift;
  logic [3:0]            bit_cnt;
  logic                  parity_acc;

  // Frame snapshot, captured on the pop edge only.
  logic [1:0]            snap_bits;
  logic [1:0]            snap_parity;
  logic                  snap_double;

  logic                  can_pop;
  logic                  frame_end;
  logic                  pop;
  logic                  parity_on;
  logic [3:0]            frame_bits;

  always_comb begin
    can_pop    = enable && !fifo.fifo_empty;
    // Closing tick of the last stop bit.
    frame_end  = bit_tick && (((state == STOP1) && !snap_double) || (state == STOP2));
    pop        = !reset && can_pop && ((state == IDLE) || frame_end);
    parity_on  = (snap_parity == 2'b01) || (snap_parity == 2'b10);
    frame_bits = {2'b00, snap_bits} + 4'd5;
  end

  assign fifo.fifo_re = pop;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      tx_done     <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      parity_acc  <= 1'b0;
      snap_bits   <= '0;
      snap_parity <= '0;
      snap_double <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (pop) begin
        shift       <= fifo.fifo_dout;
        snap_bits   <= data_bits_count;
        snap_parity <= parity_type;
        snap_double <= double_stop_bits;
      end

      case (state)
        IDLE: begin
          if (pop) state <= LOAD;
        end

        // Waits for a tick so the start bit lasts a full bit period.
        LOAD: begin
          if (bit_tick) begin
            state <= START;
            tx    <= 1'b0;
          end
        end

        START: begin
          if (bit_tick) begin
            state      <= DATA;
            tx         <= shift[0];
            shift      <= shift >> 1;
            bit_cnt    <= 4'd1;
            parity_acc <= shift[0];
          end
        end

        DATA: begin
          if (bit_tick) begin
            if (bit_cnt < frame_bits) begin
              tx         <= shift[0];
              shift      <= shift >> 1;
              bit_cnt    <= bit_cnt + 4'd1;
              parity_acc <= parity_acc ^ shift[0];
            end else if (parity_on) begin
              state <= PARITY;
              tx    <= (snap_parity == 2'b10) ? parity_acc : ~parity_acc;
            end else begin
              state <= STOP1;
              tx    <= 1'b1;
            end
          end
        end

        PARITY: begin
          if (bit_tick) begin
            state <= STOP1;
            tx    <= 1'b1;
          end
        end

        STOP1, STOP2: begin
          if (bit_tick) begin
            if ((state == STOP1) && snap_double) begin
              state <= STOP2;
            end else if (pop) begin
              // Next byte already latched above: go straight to the start bit.
              state <= START;
              tx    <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_done <= fifo.fifo_empty;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
